// File: rtl/fsm_dispatch_pkg.sv
// rtl/fsm_dispatch_pkg.sv - shared opcodes, start-pulse codes, field positions and states for the dispatcher
package fsm_dispatch_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int P1_HI = 11;
    localparam int P1_LO = 6;
    localparam int P2_HI = 5;
    localparam int P2_LO = 0;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_CMP   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_INC   = 4'h8;
    localparam logic [3:0] OP_DEC   = 4'h9;
    localparam logic [3:0] OP_MOVE  = 4'hA;
    localparam logic [3:0] OP_MOVI  = 4'hB;
    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;

    localparam logic [6:0] FSM_BLANK    = 7'b0000000;
    localparam logic [6:0] FSM_ALU_PAR2 = 7'b0000001;
    localparam logic [6:0] FSM_ALU_PAR1 = 7'b0000010;
    localparam logic [6:0] FSM_ALU_NOT  = 7'b0000100;
    localparam logic [6:0] FSM_MOVE     = 7'b0001000;
    localparam logic [6:0] FSM_MOVI     = 7'b0010000;
    localparam logic [6:0] FSM_LOAD     = 7'b0100000;
    localparam logic [6:0] FSM_STORE    = 7'b1000000;
    localparam logic [6:0] FSM_ERROR    = 7'b1111111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_DISPATCH,
        S_EXEC,
        S_ERROR
    } state_e;

endpackage

// File: rtl/fsm_dispatch_if.sv
// rtl/fsm_dispatch_if.sv - memory fetch handshake and sub-FSM start/done bus
interface fsm_dispatch_if #(
    parameter int PC_W = 8
);
    logic            memRead;
    logic [PC_W-1:0] memAddr;
    logic            mfc;
    logic [15:0]     memData;
    logic [6:0]      nextFSM;
    logic [3:0]      aluOp;
    logic [5:0]      para1;
    logic [5:0]      para2;
    logic [6:0]      resFsm;

    modport master (
        output memRead, memAddr, nextFSM, aluOp, para1, para2,
        input  mfc, memData, resFsm
    );

    modport slave (
        input  memRead, memAddr, nextFSM, aluOp, para1, para2,
        output mfc, memData, resFsm
    );
endinterface

// File: rtl/op_fsm_decode.sv
// rtl/op_fsm_decode.sv - opcode to one-hot execute-FSM class, flags unassigned opcodes
module op_fsm_decode
    import fsm_dispatch_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [6:0] fsm_class,
    output logic       illegal
);

    always_comb begin
        fsm_class = FSM_BLANK;
        illegal   = FALSE;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_CMP:  fsm_class = FSM_ALU_PAR2;
            OP_INC, OP_DEC:         fsm_class = FSM_ALU_PAR1;
            OP_NOT:                 fsm_class = FSM_ALU_NOT;
            OP_MOVE:                fsm_class = FSM_MOVE;
            OP_MOVI:                fsm_class = FSM_MOVI;
            OP_LOAD:                fsm_class = FSM_LOAD;
            OP_STORE:               fsm_class = FSM_STORE;
            default:                illegal   = TRUE;
        endcase
    end

endmodule

// File: rtl/fsm_dispatch.sv
// rtl/fsm_dispatch.sv - fetch/decode/dispatch controller for the execute sub-FSMs
module fsm_dispatch
    import fsm_dispatch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    fsm_dispatch_if.master bus,
    output logic           busy,
    output logic           error
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e           state, state_nx;
    logic [PC_W-1:0]  pc, pc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [15:0]      ir, ir_nx;
    logic [6:0]       cls, cls_nx;
    logic             mem_read_q, mem_read_nx;
    logic [6:0]       next_fsm_q, next_fsm_nx;
    logic [3:0]       alu_op_q, alu_op_nx;
    logic [5:0]       para1_q, para1_nx;
    logic [5:0]       para2_q, para2_nx;
    logic             busy_q, busy_nx;
    logic             error_q, error_nx;
    logic [6:0]       dec_class;
    logic             dec_illegal;
    logic             res_hit;

    op_fsm_decode u_decode (
        .opcode    (ir[OP_HI:OP_LO]),
        .fsm_class (dec_class),
        .illegal   (dec_illegal)
    );

    // Only the done bit of the class that was started counts.
    assign res_hit = |(bus.resFsm & cls);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= '0;
            cnt        <= '0;
            ir         <= '0;
            cls        <= FSM_BLANK;
            mem_read_q <= 1'b0;
            next_fsm_q <= FSM_BLANK;
            alu_op_q   <= '0;
            para1_q    <= '0;
            para2_q    <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            cnt        <= cnt_nx;
            ir         <= ir_nx;
            cls        <= cls_nx;
            mem_read_q <= mem_read_nx;
            next_fsm_q <= next_fsm_nx;
            alu_op_q   <= alu_op_nx;
            para1_q    <= para1_nx;
            para2_q    <= para2_nx;
            busy_q     <= busy_nx;
            error_q    <= error_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:    if (run) state_nx = S_FWAIT;
            S_FWAIT:    if (bus.mfc) state_nx = S_DECODE;
                        else if (cnt == CNT_MAX) state_nx = S_ERROR;
            S_DECODE:   state_nx = dec_illegal ? S_ERROR : S_DISPATCH;
            S_DISPATCH: state_nx = S_EXEC;
            S_EXEC:     if (res_hit) state_nx = S_FETCH;
                        else if (cnt == CNT_MAX) state_nx = S_ERROR;
            S_ERROR:    state_nx = S_ERROR;
            default:    state_nx = S_ERROR;
        endcase
    end

    // Outputs are computed from the upcoming state so every port is a flop.
    always_comb begin
        pc_nx     = pc;
        cnt_nx    = cnt;
        ir_nx     = ir;
        cls_nx    = cls;
        alu_op_nx = alu_op_q;
        para1_nx  = para1_q;
        para2_nx  = para2_q;
        case (state)
            S_FETCH:    cnt_nx = '0;
            S_FWAIT:    if (bus.mfc) ir_nx = bus.memData;
                        else cnt_nx = cnt + 1'b1;
            S_DECODE: begin
                alu_op_nx = ir[OP_HI:OP_LO];
                para1_nx  = ir[P1_HI:P1_LO];
                para2_nx  = ir[P2_HI:P2_LO];
                cls_nx    = dec_class;
            end
            S_DISPATCH: cnt_nx = '0;
            S_EXEC:     if (res_hit) pc_nx = pc + 1'b1;
                        else cnt_nx = cnt + 1'b1;
            default:    ;
        endcase
        mem_read_nx = (state_nx == S_FWAIT);
        busy_nx     = (state_nx == S_DISPATCH) || (state_nx == S_EXEC);
        error_nx    = (state_nx == S_ERROR);
        if (state_nx == S_DISPATCH)   next_fsm_nx = dec_class;
        else if (state_nx == S_ERROR) next_fsm_nx = FSM_ERROR;
        else                          next_fsm_nx = FSM_BLANK;
    end

    assign bus.memRead = mem_read_q;
    assign bus.memAddr = pc;
    assign bus.nextFSM = next_fsm_q;
    assign bus.aluOp   = alu_op_q;
    assign bus.para1   = para1_q;
    assign bus.para2   = para2_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule
